gnn_input_loader: RTL and testbench



---
 rtl/gnn_input_loader.sv | 152 +++++++++++++++
 tb/tb_gnn_input_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_input_loader.sv
// ============================================================================
// gnn_input_loader: assembles 40-word operand frames from a valid/ready
// stream and hands them to the GNN top through a double-buffered commit.
// Revision 1.0
// ============================================================================
`default_nettype none

module gnn_input_loader #(
    parameter int DW = 5,
    parameter int NF = 16,
    parameter int NW = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    input  logic                 done_i,
    output logic signed [DW-1:0] x0_node0, x1_node0, x2_node0, x3_node0,
    output logic signed [DW-1:0] x0_node1, x1_node1, x2_node1, x3_node1,
    output logic signed [DW-1:0] x0_node2, x1_node2, x2_node2, x3_node2,
    output logic signed [DW-1:0] x0_node3, x1_node3, x2_node3, x3_node3,
    output logic signed [DW-1:0] w04, w14, w24, w34,
    output logic signed [DW-1:0] w05, w15, w25, w35,
    output logic signed [DW-1:0] w06, w16, w26, w36,
    output logic signed [DW-1:0] w07, w17, w27, w37,
    output logic signed [DW-1:0] w48, w58, w68, w78,
    output logic signed [DW-1:0] w49, w59, w69, w79,
    output logic                 in_ready,
    output logic                 frame_err,
    output logic [7:0]           frame_cnt
);

    localparam int          NT   = NF + NW;
    localparam logic [5:0]  LAST = 6'(NT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, FIRE = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [5:0]     wcnt_q, wcnt_d;
    logic           stage_full_q, stage_full_d;
    logic           frame_err_q, frame_err_d;
    logic           in_ready_q, in_ready_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic [DW-1:0]  stage_q [NT];
    logic [DW-1:0]  stage_d [NT];
    logic [DW-1:0]  op_q [NT];
    logic [DW-1:0]  op_d [NT];
    logic           accept;

    assign s_ready   = ~stage_full_q;
    assign accept    = s_valid & s_ready;
    assign in_ready  = in_ready_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        stage_full_d = stage_full_q;
        frame_err_d  = 1'b0;
        in_ready_d   = in_ready_q;
        frame_cnt_d  = frame_cnt_q;
        stage_d      = stage_q;
        op_d         = op_q;

        // A misplaced or missing s_last discards the whole partial frame.
        if (accept) begin
            stage_d[wcnt_q] = s_data;
            if (wcnt_q == LAST) begin
                wcnt_d = 6'd0;
                if (s_last) begin
                    stage_full_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else if (s_last) begin
                wcnt_d      = 6'd0;
                frame_err_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 6'd1;
            end
        end

        // stage_full_q=1 blocks accept, so the commit clear never races a set.
        case (state_q)
            IDLE: begin
                if (stage_full_q) begin
                    op_d         = stage_q;
                    stage_full_d = 1'b0;
                    state_d      = ARM;
                end
            end
            ARM: begin
                in_ready_d = 1'b1;
                state_d    = FIRE;
            end
            FIRE: begin
                if (done_i) begin
                    in_ready_d  = 1'b0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wcnt_q       <= 6'd0;
            stage_full_q <= 1'b0;
            frame_err_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            frame_cnt_q  <= 8'd0;
            for (int i = 0; i < NT; i++) begin
                stage_q[i] <= '0;
                op_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            stage_full_q <= stage_full_d;
            frame_err_q  <= frame_err_d;
            in_ready_q   <= in_ready_d;
            frame_cnt_q  <= frame_cnt_d;
            stage_q      <= stage_d;
            op_q         <= op_d;
        end
    end

    // Frame word order: node-major features, then weights in stream order.
    assign x0_node0 = op_q[0];   assign x1_node0 = op_q[1];
    assign x2_node0 = op_q[2];   assign x3_node0 = op_q[3];
    assign x0_node1 = op_q[4];   assign x1_node1 = op_q[5];
    assign x2_node1 = op_q[6];   assign x3_node1 = op_q[7];
    assign x0_node2 = op_q[8];   assign x1_node2 = op_q[9];
    assign x2_node2 = op_q[10];  assign x3_node2 = op_q[11];
    assign x0_node3 = op_q[12];  assign x1_node3 = op_q[13];
    assign x2_node3 = op_q[14];  assign x3_node3 = op_q[15];
    assign w04 = op_q[16];  assign w14 = op_q[17];  assign w24 = op_q[18];  assign w34 = op_q[19];
    assign w05 = op_q[20];  assign w15 = op_q[21];  assign w25 = op_q[22];  assign w35 = op_q[23];
    assign w06 = op_q[24];  assign w16 = op_q[25];  assign w26 = op_q[26];  assign w36 = op_q[27];
    assign w07 = op_q[28];  assign w17 = op_q[29];  assign w27 = op_q[30];  assign w37 = op_q[31];
    assign w48 = op_q[32];  assign w58 = op_q[33];  assign w68 = op_q[34];  assign w78 = op_q[35];
    assign w49 = op_q[36];  assign w59 = op_q[37];  assign w69 = op_q[38];  assign w79 = op_q[39];

endmodule

`default_nettype wire

// File: tb/tb_gnn_input_loader.sv
// ============================================================================
// tb_gnn_input_loader: directed self-checking bench for gnn_input_loader.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_gnn_input_loader;

    localparam int DW = 5;
    localparam int NT = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          done_i = 1'b0;
    logic          s_ready, in_ready, frame_err;
    logic [7:0]    frame_cnt;
    logic [DW-1:0] ops [0:NT-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gnn_input_loader #(.DW(5), .NF(16), .NW(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .done_i(done_i),
        .x0_node0(ops[0]),  .x1_node0(ops[1]),  .x2_node0(ops[2]),  .x3_node0(ops[3]),
        .x0_node1(ops[4]),  .x1_node1(ops[5]),  .x2_node1(ops[6]),  .x3_node1(ops[7]),
        .x0_node2(ops[8]),  .x1_node2(ops[9]),  .x2_node2(ops[10]), .x3_node2(ops[11]),
        .x0_node3(ops[12]), .x1_node3(ops[13]), .x2_node3(ops[14]), .x3_node3(ops[15]),
        .w04(ops[16]), .w14(ops[17]), .w24(ops[18]), .w34(ops[19]),
        .w05(ops[20]), .w15(ops[21]), .w25(ops[22]), .w35(ops[23]),
        .w06(ops[24]), .w16(ops[25]), .w26(ops[26]), .w36(ops[27]),
        .w07(ops[28]), .w17(ops[29]), .w27(ops[30]), .w37(ops[31]),
        .w48(ops[32]), .w58(ops[33]), .w68(ops[34]), .w78(ops[35]),
        .w49(ops[36]), .w59(ops[37]), .w69(ops[38]), .w79(ops[39]),
        .in_ready(in_ready), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    // Pattern 0 is 1..16, -1..-16, -2..-9 (5-bit two's complement).
    function automatic logic [DW-1:0] pat(input int id, input int k);
        int v;
        case (id)
            0:       v = (k < 16) ? k + 1 : (k < 32) ? -(k - 15) : -(k - 30);
            1:       v = k * 3 + 1;
            2:       v = 31 - k;
            3:       v = 7;
            4:       v = k ^ 5;
            default: v = k * 5 + 2;
        endcase
        return v[DW-1:0];
    endfunction

    task automatic send_word(input logic [DW-1:0] d, input logic last, input bit gaps);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) begin @(posedge clk); #1; end
        end
        s_valid = 1'b1; s_data = d; s_last = last;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 100) begin n++; @(negedge clk); end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL s_ready_timeout got %0b exp 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input int id, input int nwords, input int last_at, input bit gaps);
        for (int k = 0; k < nwords; k++) send_word(pat(id, k), (k == last_at), gaps);
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %0b exp 0", frame_err); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got %0b exp 1", s_ready); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (ops[k] !== '0) begin errors++; $display("FAIL rst_op[%0d] got %0d exp 0", k, ops[k]); end
        end
    endtask

    task automatic test_basic();
        send_frame(0, NT, NT - 1, 1'b0);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready_drop got %0b exp 0", s_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_e0 got %0b exp 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_e1 got %0b exp 0", in_ready); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_s_ready_rise got %0b exp 1", s_ready); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (ops[k] !== pat(0, k)) begin errors++; $display("FAIL basic_op[%0d] got %0d exp %0d", k, ops[k], pat(0, k)); end
        end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_e2 got %0b exp 1", in_ready); end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_hold got %0b exp 1", in_ready); end
        pulse_done();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_fall got %0b exp 0", in_ready); end
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL basic_frame_cnt got %0d exp 1", frame_cnt); end
    endtask

    task automatic test_gaps();
        send_frame(0, NT, NT - 1, 1'b1);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL gaps_s_ready_drop got %0b exp 0", s_ready); end
        @(posedge clk); #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL gaps_s_ready_rise got %0b exp 1", s_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL gaps_in_ready got %0b exp 1", in_ready); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (ops[k] !== pat(0, k)) begin errors++; $display("FAIL gaps_op[%0d] got %0d exp %0d", k, ops[k], pat(0, k)); end
        end
        pulse_done();
        checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL gaps_frame_cnt got %0d exp 2", frame_cnt); end
    endtask

    task automatic test_early_last();
        send_frame(2, 10, 9, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_err_pulse got %0b exp 1", frame_err); end
        @(posedge clk); #1;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL early_err_clear got %0b exp 0", frame_err); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL early_s_ready got %0b exp 1", s_ready); end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL early_in_ready got %0b exp 0", in_ready); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (ops[k] !== pat(0, k)) begin errors++; $display("FAIL early_hold_op[%0d] got %0d exp %0d", k, ops[k], pat(0, k)); end
        end
        send_frame(1, NT, NT - 1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL early_good_in_ready got %0b exp 1", in_ready); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (ops[k] !== pat(1, k)) begin errors++; $display("FAIL early_good_op[%0d] got %0d exp %0d", k, ops[k], pat(1, k)); end
        end
        pulse_done();
        checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL early_frame_cnt got %0d exp 3", frame_cnt); end
    endtask

    task automatic test_missing_last();
        send_frame(2, NT, -1, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL miss_err_pulse got %0b exp 1", frame_err); end
        @(posedge clk); #1;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL miss_err_clear got %0b exp 0", frame_err); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL miss_in_ready got %0b exp 0", in_ready); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (ops[k] !== pat(1, k)) begin errors++; $display("FAIL miss_hold_op[%0d] got %0d exp %0d", k, ops[k], pat(1, k)); end
        end
        send_frame(4, NT, NT - 1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL miss_good_in_ready got %0b exp 1", in_ready); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (ops[k] !== pat(4, k)) begin errors++; $display("FAIL miss_good_op[%0d] got %0d exp %0d", k, ops[k], pat(4, k)); end
        end
        pulse_done();
        checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL miss_frame_cnt got %0d exp 4", frame_cnt); end
    endtask

    task automatic test_overlap();
        send_frame(1, NT, NT - 1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ovl_a_in_ready got %0b exp 1", in_ready); end
        send_frame(3, NT, NT - 1, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL ovl_s_ready_held got %0b exp 0", s_ready); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ovl_in_ready_held got %0b exp 1", in_ready); end
        end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (ops[k] !== pat(1, k)) begin errors++; $display("FAIL ovl_a_op[%0d] got %0d exp %0d", k, ops[k], pat(1, k)); end
        end
        pulse_done();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovl_fall got %0b exp 0", in_ready); end
        checks++; if (frame_cnt !== 8'd5) begin errors++; $display("FAIL ovl_frame_cnt got %0d exp 5", frame_cnt); end
        checks++; if (ops[0] !== pat(1, 0)) begin errors++; $display("FAIL ovl_a_still got %0d exp %0d", ops[0], pat(1, 0)); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovl_low2 got %0b exp 0", in_ready); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ovl_s_ready_rise got %0b exp 1", s_ready); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (ops[k] !== pat(3, k)) begin errors++; $display("FAIL ovl_b_op[%0d] got %0d exp %0d", k, ops[k], pat(3, k)); end
        end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ovl_b_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        send_frame(2, 20, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready got %0b exp 0", in_ready); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rmid_frame_cnt got %0d exp 0", frame_cnt); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rmid_s_ready got %0b exp 1", s_ready); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (ops[k] !== '0) begin errors++; $display("FAIL rmid_op[%0d] got %0d exp 0", k, ops[k]); end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(5, NT, NT - 1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_new_in_ready got %0b exp 1", in_ready); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (ops[k] !== pat(5, k)) begin errors++; $display("FAIL rmid_new_op[%0d] got %0d exp %0d", k, ops[k], pat(5, k)); end
        end
        pulse_done();
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL rmid_frame_cnt_after got %0d exp 1", frame_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_gaps();
        test_early_last();
        test_missing_last();
        test_overlap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
